// File: rtl/ram_store_align.sv
// Store alignment: turns one (addr, size, data) store into lane-aligned 64-bit write beats with byte strobes.
// STORE_MISALIGN_SPLIT_EN: when defined, 8-byte-crossing stores become two beats; otherwise they are rejected with store_err.
module ram_store_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_type,
  input  logic [63:0] req_data,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  output logic        store_done,
  output logic        store_err
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

`ifdef STORE_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND0 = 2'd1, SEND1 = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND0 = 2'd1} state_e;
`endif

  state_e              state_q;
  logic                wvalid_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                done_q;

  logic [STRB_W-1:0]   mask_c;
  logic [DATA_W-1:0]   trunc_c;
  logic [5:0]          shamt_c;
  logic [2*STRB_W-1:0] strb_c;
  logic                crossing_c;
  logic [ADDR_W-1:0]   base_c;
  logic [DATA_W-1:0]   lo_data_c;

  // Byte mask of the access size, and request data with bytes above that size zeroed
  always_comb begin
    mask_c = 8'hFF;
    case (req_type)
      2'b00:   mask_c = 8'h01;
      2'b01:   mask_c = 8'h03;
      2'b10:   mask_c = 8'h0F;
      default: mask_c = 8'hFF;
    endcase
    trunc_c = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      trunc_c[8*i +: 8] = mask_c[i] ? req_data[8*i +: 8] : 8'h00;
    end
  end

  assign shamt_c    = {req_addr[2:0], 3'b000};
  assign strb_c     = 16'(mask_c) << req_addr[2:0];
  assign crossing_c = |strb_c[15:8];
  assign base_c     = {req_addr[ADDR_W-1:3], 3'b000};

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [2*DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0]   hi_data_c;
  logic [ADDR_W-1:0]   hi_addr_c;
  logic                pend_q;
  logic [ADDR_W-1:0]   hi_waddr_q;
  logic [DATA_W-1:0]   hi_wdata_q;
  logic [STRB_W-1:0]   hi_wstrb_q;

  assign shifted_c = {64'd0, trunc_c} << shamt_c;
  assign lo_data_c = shifted_c[DATA_W-1:0];
  assign hi_data_c = shifted_c[2*DATA_W-1:DATA_W];
  // Wraps modulo 2^64 at the top of the address space
  assign hi_addr_c = {req_addr[ADDR_W-1:3] + 61'd1, 3'b000};
  assign store_err = 1'b0;
`else
  logic err_q;

  assign lo_data_c = trunc_c << shamt_c;
  assign store_err = err_q;
`endif

  // Request acceptance, beat sequencing and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wvalid_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      done_q     <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      pend_q     <= 1'b0;
      hi_waddr_q <= '0;
      hi_wdata_q <= '0;
      hi_wstrb_q <= '0;
`else
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifndef STORE_MISALIGN_SPLIT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            pend_q     <= crossing_c;
            hi_waddr_q <= hi_addr_c;
            hi_wdata_q <= hi_data_c;
            hi_wstrb_q <= strb_c[15:8];
            wvalid_q   <= 1'b1;
            waddr_q    <= base_c;
            wdata_q    <= lo_data_c;
            wstrb_q    <= strb_c[7:0];
            state_q    <= SEND0;
`else
            if (crossing_c) begin
              err_q <= 1'b1;
            end else begin
              wvalid_q <= 1'b1;
              waddr_q  <= base_c;
              wdata_q  <= lo_data_c;
              wstrb_q  <= strb_c[7:0];
              state_q  <= SEND0;
            end
`endif
          end
        end
        SEND0: begin
          if (mem_wready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            if (pend_q) begin
              pend_q  <= 1'b0;
              waddr_q <= hi_waddr_q;
              wdata_q <= hi_wdata_q;
              wstrb_q <= hi_wstrb_q;
              state_q <= SEND1;
            end else
`endif
            begin
              wvalid_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
`ifdef STORE_MISALIGN_SPLIT_EN
        SEND1: begin
          if (mem_wready) begin
            wvalid_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) & ~rst;
  assign mem_wvalid = wvalid_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign store_done = done_q;

endmodule

// File: tb/tb_ram_store_align.sv
// Self-checking bench for ram_store_align: directed and random stores against a byte-level reference model.
module tb_ram_store_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_type;
  logic [63:0] req_data;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        store_done;
  logic        store_err;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_addr [2];
  logic [63:0] exp_data [2];
  logic [7:0]  exp_strb [2];
  int          exp_nb;

  ram_store_align dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_type   (req_type),
    .req_data   (req_data),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .store_done (store_done),
    .store_err  (store_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: place each store byte at its absolute byte position, then split by 8-byte line
  function automatic void build_model(input logic [63:0] addr, input logic [1:0] typ,
                                      input logic [63:0] data);
    int n;
    int off;
    int pos;
    n = 1 << typ;
    off = int'(addr[2:0]);
    exp_addr[0] = addr & ~64'h7;
    exp_addr[1] = exp_addr[0] + 64'd8;
    for (int b = 0; b < 2; b++) begin
      exp_data[b] = '0;
      exp_strb[b] = '0;
    end
    for (int i = 0; i < n; i++) begin
      pos = off + i;
      exp_data[pos / 8][8*(pos % 8) +: 8] = data[8*i +: 8];
      exp_strb[pos / 8][pos % 8] = 1'b1;
    end
    exp_nb = (off + n > 8) ? 2 : 1;
  endfunction

  // Issue one store starting at a negedge, stall each beat 'stall' cycles, check every cycle
  task automatic run_store(input logic [63:0] addr, input logic [1:0] typ, input logic [63:0] data,
                           input int stall, input string name);
    logic [139:0] act;
    logic [139:0] expv;
    build_model(addr, typ, data);
    req_addr  = addr;
    req_type  = typ;
    req_data  = data;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready: got %b exp 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = {$urandom, $urandom};
    req_addr  = {$urandom, $urandom};
`ifndef STORE_MISALIGN_SPLIT_EN
    if (exp_nb == 2) begin
      checks++;
      if ({mem_wvalid, store_err, store_done, req_ready} !== 4'b0101) begin
        failures++;
        $display("FAIL %s reject: got wv/err/done/rdy %b%b%b%b exp 0101", name,
                 mem_wvalid, store_err, store_done, req_ready);
      end
      @(negedge clk);
      checks++;
      if ({mem_wvalid, store_err, store_done} !== 3'b000) begin
        failures++;
        $display("FAIL %s reject_end: got wv/err/done %b%b%b exp 000", name,
                 mem_wvalid, store_err, store_done);
      end
      return;
    end
`endif
    for (int b = 0; b < exp_nb; b++) begin
      for (int s = 0; s <= stall; s++) begin
        act  = {mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, req_ready, store_done, store_err};
        expv = {1'b1, exp_addr[b], exp_data[b], exp_strb[b], 3'b000};
        checks++;
        if (act !== expv) begin
          failures++;
          $display("FAIL %s beat%0d cyc%0d: got %h exp %h", name, b, s, act, expv);
        end
        mem_wready = (s == stall);
        @(negedge clk);
      end
      mem_wready = 1'b0;
    end
    checks++;
    if ({mem_wvalid, store_done, store_err, req_ready} !== 4'b0101) begin
      failures++;
      $display("FAIL %s done: got wv/done/err/rdy %b%b%b%b exp 0101", name,
               mem_wvalid, store_done, store_err, req_ready);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, store_done} !== 2'b00) begin
      failures++;
      $display("FAIL %s done_pulse: got wv/done %b%b exp 00", name, mem_wvalid, store_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_type = '0; req_data = '0; mem_wready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, store_done, store_err, req_ready} !== 140'd0) begin
      failures++;
      $display("FAIL reset_values: got %h exp 0",
               {mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, store_done, store_err, req_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_idle_wready();
    mem_wready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({mem_wvalid, store_done, store_err, req_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL idle_wready: got wv/done/err/rdy %b%b%b%b exp 0001",
                 mem_wvalid, store_done, store_err, req_ready);
      end
    end
    mem_wready = 1'b0;
  endtask

  task automatic test_directed();
    run_store(64'h1000, 2'b11, 64'h1122334455667788, 0, "sd_aligned");
    run_store(64'h1003, 2'b00, 64'hFFFF_FFFF_FFFF_FFAB, 0, "sb_off3");
    run_store(64'h1006, 2'b10, 64'h0000_0000_DEAD_BEEF, 0, "sw_cross");
    run_store(64'h2002, 2'b01, 64'h0000_0000_0000_1234, 3, "sh_stall");
    run_store(64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h5A5A_5A5A_5A5A_C3D2, 1, "sh_wrap");
    run_store(64'h7, 2'b11, 64'h0102030405060708, 2, "sd_off7");
  endtask

  task automatic test_reset_mid();
    req_addr = 64'h2002; req_type = 2'b01; req_data = 64'h1234; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wvalid, store_done, store_err, req_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_send0: got wv/done/err/rdy %b%b%b%b exp 0000",
               mem_wvalid, store_done, store_err, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_wvalid, store_done, req_ready} !== 3'b001) begin
      failures++;
      $display("FAIL rst_send0_after: got wv/done/rdy %b%b%b exp 001", mem_wvalid, store_done, req_ready);
    end
`ifdef STORE_MISALIGN_SPLIT_EN
    build_model(64'h3004, 2'b11, 64'hCAFE_F00D_1234_5678);
    req_addr = 64'h3004; req_type = 2'b11; req_data = 64'hCAFE_F00D_1234_5678; req_valid = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    mem_wready = 1'b1;
    @(negedge clk);
    mem_wready = 1'b0;
    checks++;
    if ({mem_wvalid, mem_waddr, mem_wstrb} !== {1'b1, exp_addr[1], exp_strb[1]}) begin
      failures++;
      $display("FAIL rst_send1_beat1: got %h exp %h", {mem_wvalid, mem_waddr, mem_wstrb},
               {1'b1, exp_addr[1], exp_strb[1]});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mem_wvalid, store_done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_send1: got wv/done %b%b exp 00", mem_wvalid, store_done);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, store_done, req_ready} !== 3'b001) begin
      failures++;
      $display("FAIL rst_send1_after: got wv/done/rdy %b%b%b exp 001", mem_wvalid, store_done, req_ready);
    end
`endif
    run_store(64'h4005, 2'b00, 64'h77, 0, "sb_after_rst");
  endtask

  // Hold req_valid and mem_wready high; count beats and completions over a fixed window
  task automatic back_to_back(input logic [63:0] addr, input logic [1:0] typ, input logic [63:0] data,
                              input int ncyc, input int want_beats, input int want_dones, input string name);
    int beats = 0;
    int dones = 0;
    int idx;
    build_model(addr, typ, data);
    req_addr = addr; req_type = typ; req_data = data; req_valid = 1'b1; mem_wready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (mem_wvalid) begin
        idx = beats % exp_nb;
        checks++;
        if ({mem_waddr, mem_wdata, mem_wstrb} !== {exp_addr[idx], exp_data[idx], exp_strb[idx]}) begin
          failures++;
          $display("FAIL %s beat%0d: got %h exp %h", name, beats, {mem_waddr, mem_wdata, mem_wstrb},
                   {exp_addr[idx], exp_data[idx], exp_strb[idx]});
        end
        beats++;
      end
      if (store_done) dones++;
    end
    req_valid = 1'b0;
    mem_wready = 1'b0;
    checks++;
    if (beats != want_beats || dones != want_dones) begin
      failures++;
      $display("FAIL %s throughput: got beats=%0d dones=%0d exp beats=%0d dones=%0d",
               name, beats, dones, want_beats, want_dones);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    back_to_back(64'h5000, 2'b11, {$urandom, $urandom}, 20, 10, 10, "b2b_sd");
`ifdef STORE_MISALIGN_SPLIT_EN
    back_to_back(64'h6007, 2'b01, 64'hBEEF, 21, 14, 7, "b2b_cross");
`endif
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] d;
    logic [1:0]  t;
    for (int k = 0; k < 60; k++) begin
      a = {$urandom, $urandom};
      if (k % 10 == 0) a = {61'h1FFF_FFFF_FFFF_FFFF, a[2:0]};
      d = {$urandom, $urandom};
      t = 2'($urandom_range(0, 3));
      run_store(a, t, d, int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_idle_wready();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
